// File: rtl/frame_rx_pkg.sv
// Shared definitions for the serial frame receive/transmit path.
package frame_rx_pkg;

  localparam int FRAME_W_DEF      = 9;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module rx_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next-state: shift the async input through both stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // both stages reset to the line's idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/frame_receiver.sv
// Serial frame receiver: start detect, mid-bit sampling, LSB-first assembly,
// one-cycle frame_valid / frame_error strobes.
module frame_receiver
  import frame_rx_pkg::*;
#(
  parameter int FRAME_W      = FRAME_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               rx,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               frame_error,
  output logic               busy
);

  localparam int IDX_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_W - 1);

  logic               rx_s;
  logic               start_edge;
  rx_state_e          state_q, state_d;
  logic               rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;

  rx_synchronizer #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign start_edge = !rx_s && rx_prev_q;

  // next-state: FSM, bit timer (cleared at each sample point), shift register
  always_comb begin
    state_d   = state_q;
    rx_prev_d = rx_s;
    timer_d   = timer_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[FRAME_W-1:1]};
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = IDLE;
          if (rx_s) begin
            frame_d = shift_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
      frame_d = frame_q;
      valid_d = 1'b0;
      error_d = 1'b0;
    end

    // busy is registered so that it stays high through the pulse cycle,
    // in which the FSM itself has already returned to IDLE
    busy_d = (state_d != IDLE) || valid_d || error_d;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_prev_q <= 1'b1;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_prev_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign busy        = busy_q;

endmodule
